camerametnios_nios2_gen2_0_cpu_mult_combine: RTL and testbench

Downstream stage of the CPU multiply cell. Consumes the three registered 16x16 partial products (lo·lo, lo·hi, hi·lo) in the M stage and assembles the 32-bit MUL result for the A stage. With the high-word feature compiled in, it also produces MULXUU/MULXSU/MULXSS results. It computes the missing hi·hi product with a 16-cycle serial multiplier and stalls the pipeline while it runs.

---
 rtl/nios_mul_pkg.sv | 19 +
 rtl/nios_mul_hh_serial.sv | 62 ++++++
 rtl/camerametnios_nios2_gen2_0_cpu_mult_combine.sv | 138 +++++++++++++
 tb/tb_camerametnios_nios2_gen2_0_cpu_mult_combine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_mul_pkg.sv
// Shared widths, opcodes and state encoding for the CPU multiply combine stage.
package nios_mul_pkg;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned HALF_W   = 16;
  localparam int unsigned ITER_CNT = 16;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULXUU = 2'b01,
    MULXSU = 2'b10,
    MULXSS = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FINAL
  } mul_state_e;
endpackage

// File: rtl/nios_mul_hh_serial.sv
// 16x16 unsigned shift-add multiplier: one multiplier bit per cycle after start.
module nios_mul_hh_serial
  import nios_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic [DATA_W-1:0] product,
  output logic              done
);
  localparam logic [3:0] LAST = 4'(ITER_CNT - 1);

  logic              busy_q, busy_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [HALF_W-1:0] b_q, b_d;

  // done flags the cycle in which the final bit is being folded in,
  // so the accumulator is complete right after this edge.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    done   = busy_q && (cnt_q == LAST);
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      a_d    = {{(DATA_W-HALF_W){1'b0}}, a};
      b_d    = b;
      acc_d  = '0;
    end else if (busy_q) begin
      if (b_q[0]) acc_d = acc_q + a_q;
      a_d   = {a_q[DATA_W-2:0], 1'b0};
      b_d   = {1'b0, b_q[HALF_W-1:1]};
      cnt_d = cnt_q + 4'd1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
    end
  end

  assign product = acc_q;
endmodule

// File: rtl/camerametnios_nios2_gen2_0_cpu_mult_combine.sv
// Combines the three 16x16 partial products into MUL results; define MUL_HI_EN
// to add the serial hi*hi path and signed correction for MULXUU/MULXSU/MULXSS.
module camerametnios_nios2_gen2_0_cpu_mult_combine
  import nios_mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  input  logic [31:0] M_src1,
  input  logic [31:0] M_src2,
  input  logic [1:0]  M_op,
  input  logic        M_valid,
  input  logic        A_en,
  output logic [31:0] A_mul_result,
  output logic        A_mul_valid,
  output logic        A_mul_stall
);
  logic [DATA_W:0]   mid_sum, low_sum;
  logic [DATA_W-1:0] result_q, result_d;
  logic              valid_q, valid_d;

  assign mid_sum = {1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3};
  assign low_sum = {1'b0, M_mul_cell_p1} + {1'b0, mid_sum[HALF_W-1:0], {HALF_W{1'b0}}};

`ifdef MUL_HI_EN
  mul_state_e        state_q, state_d;
  mul_op_e           op_q, op_d;
  logic [HALF_W:0]   s_hi_q, s_hi_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic              hh_start, hh_done;
  logic [DATA_W-1:0] hh_product, hi_word;

  nios_mul_hh_serial u_hh (
    .clk     (clk),
    .rst_n   (reset_n),
    .start   (hh_start),
    .a       (M_src1[DATA_W-1:HALF_W]),
    .b       (M_src2[DATA_W-1:HALF_W]),
    .product (hh_product),
    .done    (hh_done)
  );

  // Unsigned high word first, then undo the sign weight of each signed operand.
  always_comb begin
    hi_word = hh_product + {{(DATA_W-HALF_W-1){1'b0}}, s_hi_q}
                         + {{(DATA_W-1){1'b0}}, carry_q};
    if (src1_q[DATA_W-1] && (op_q == MULXSU || op_q == MULXSS)) hi_word = hi_word - src2_q;
    if (src2_q[DATA_W-1] && op_q == MULXSS)                      hi_word = hi_word - src1_q;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    s_hi_d   = s_hi_q;
    carry_d  = carry_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    valid_d  = 1'b0;
    hh_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (M_valid && A_en) begin
          if (mul_op_e'(M_op) == MUL) begin
            result_d = low_sum[DATA_W-1:0];
            valid_d  = 1'b1;
          end else begin
            state_d  = ITER;
            hh_start = 1'b1;
            op_d     = mul_op_e'(M_op);
            s_hi_d   = mid_sum[DATA_W:HALF_W];
            carry_d  = low_sum[DATA_W];
            src1_d   = M_src1;
            src2_d   = M_src2;
          end
        end
      end
      ITER:    if (hh_done) state_d = FINAL;
      FINAL: begin
        result_d = hi_word;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= MUL;
      s_hi_q  <= '0;
      carry_q <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      s_hi_q  <= s_hi_d;
      carry_q <= carry_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
    end
  end

  assign A_mul_stall = (state_q != IDLE);
`else
  logic unused_inputs;
  assign unused_inputs = ^{M_src1, M_src2, M_op, low_sum[DATA_W], mid_sum[DATA_W:HALF_W]};

  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    if (M_valid && A_en) begin
      result_d = low_sum[DATA_W-1:0];
      valid_d  = 1'b1;
    end
  end

  assign A_mul_stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign A_mul_result = result_q;
  assign A_mul_valid  = valid_q;
endmodule

// File: tb/tb_camerametnios_nios2_gen2_0_cpu_mult_combine.sv
// Scoreboarded bench for the multiply combine stage; expectations follow MUL_HI_EN.
module tb_camerametnios_nios2_gen2_0_cpu_mult_combine;
  import nios_mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] p1, p2, p3, src1, src2;
  logic [1:0]  op;
  logic        m_valid, a_en;
  logic [31:0] A_mul_result;
  logic        A_mul_valid, A_mul_stall;

  camerametnios_nios2_gen2_0_cpu_mult_combine dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .M_mul_cell_p1 (p1),
    .M_mul_cell_p2 (p2),
    .M_mul_cell_p3 (p3),
    .M_src1        (src1),
    .M_src2        (src2),
    .M_op          (op),
    .M_valid       (m_valid),
    .A_en          (a_en),
    .A_mul_result  (A_mul_result),
    .A_mul_valid   (A_mul_valid),
    .A_mul_stall   (A_mul_stall)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] exp; int unsigned at; } sb_t;
  typedef struct { logic [31:0] a; logic [31:0] b; mul_op_e op; logic [31:0] exp; } vec_t;

  sb_t         sbq[$];
  vec_t        vt[10];
  int          checks = 0, errors = 0;
  int unsigned valid_cnt = 0, stall_cnt = 0;

`ifdef MUL_HI_EN
  localparam bit HI = 1'b1;
`else
  localparam bit HI = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: widen operands per op signedness and take the 64-bit product.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input mul_op_e o);
    logic [63:0] ua, ub, p;
    ua = (HI && (o == MULXSU || o == MULXSS)) ? {{32{a[31]}}, a} : {32'b0, a};
    ub = (HI && o == MULXSS) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ua * ub;
    return (HI && o != MUL) ? p[63:32] : p[31:0];
  endfunction

  function automatic int unsigned lat(input mul_op_e o);
    return (HI && o != MUL) ? 18 : 1;
  endfunction

  // Advance to the next falling edge and act as the output monitor.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    if (reset_n) begin
      if (A_mul_stall) stall_cnt++;
      if (A_mul_valid) begin
        valid_cnt++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid at cycle %0d: got result %h, required no valid", cyc, A_mul_result);
        end else begin
          e = sbq.pop_front();
          chk("result", A_mul_result, e.exp);
          chk("latency", cyc, e.at);
        end
      end
    end
  endtask

  task automatic set_in(input logic [31:0] a, input logic [31:0] b, input mul_op_e o);
    src1 = a;
    src2 = b;
    op   = o;
    p1   = 32'(a[15:0]) * 32'(b[15:0]);
    p2   = 32'(a[15:0]) * 32'(b[31:16]);
    p3   = 32'(a[31:16]) * 32'(b[15:0]);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input mul_op_e o, input logic [31:0] exp);
    sb_t e;
    for (int n = 0; n < 50 && A_mul_stall; n++) tick();
    if (A_mul_stall) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout at cycle %0d: got stall 1, required 0", cyc);
    end
    set_in(a, b, o);
    m_valid = 1'b1;
    a_en    = 1'b1;
    e.exp = exp;
    e.at  = cyc + lat(o);
    sbq.push_back(e);
    tick();
    m_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sbq.size() != 0; n++) tick();
  endtask

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input mul_op_e o, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    vt[i].a   = a;
    vt[i].b   = b;
    vt[i].op  = o;
    vt[i].exp = HI ? exp_hi : exp_lo;
  endtask

  initial begin
    sb_t         e;
    int unsigned k, s0, v0;
    logic [31:0] ra, rb;
    mul_op_e     ro;

    set_vec(0, 32'h0001_0003, 32'h0002_0005, MUL,    32'h000B_000F, 32'h000B_000F);
    set_vec(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULXUU, 32'hFFFF_FFFE, 32'h0000_0001);
    set_vec(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULXSS, 32'h0000_0000, 32'h0000_0001);
    set_vec(3, 32'h8000_0000, 32'h0000_0002, MULXSU, 32'hFFFF_FFFF, 32'h0000_0000);
    set_vec(4, 32'h0000_0007, 32'h0000_0009, MUL,    32'h0000_003F, 32'h0000_003F);
    set_vec(5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, MULXSU, 32'h7FFF_FFFE, 32'h8000_0001);
    set_vec(6, 32'h8000_0000, 32'h8000_0000, MULXSS, 32'h4000_0000, 32'h0000_0000);
    set_vec(7, 32'hFFFF_FFFF, 32'h0000_0002, MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    set_vec(8, 32'h0001_0000, 32'h0001_0000, MULXUU, 32'h0000_0001, 32'h0000_0000);
    set_vec(9, 32'h0000_0003, 32'hFFFF_FFFB, MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    reset_n = 1'b0;
    m_valid = 1'b0;
    a_en    = 1'b1;
    set_in('0, '0, MUL);
    repeat (3) tick();
    chk("reset_result", A_mul_result, 32'h0);
    chk("reset_valid", 32'(A_mul_valid), 32'h0);
    chk("reset_stall", 32'(A_mul_stall), 32'h0);
    reset_n = 1'b1;
    tick();

    foreach (vt[i]) drive(vt[i].a, vt[i].b, vt[i].op, vt[i].exp);
    drain();

    // Stall window length for one long op.
    s0 = stall_cnt;
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, MULXUU, HI ? 32'hFFFF_FFFE : 32'h0000_0001);
    drain();
    chk("stall_cycles", stall_cnt - s0, HI ? 32'd17 : 32'd0);

    // Back-to-back MULs, one per cycle.
    v0 = valid_cnt;
    for (int i = 0; i < 3; i++) begin
      ra = 32'h0001_0000 * (i + 1) + 32'(i + 3);
      rb = 32'h0000_0100 + 32'(i);
      set_in(ra, rb, MUL);
      m_valid = 1'b1;
      e.exp = model(ra, rb, MUL);
      e.at  = cyc + 1;
      sbq.push_back(e);
      tick();
    end
    m_valid = 1'b0;
    drain();
    chk("b2b_valid_count", valid_cnt - v0, 32'd3);

    // A_en low in IDLE must not accept.
    v0 = valid_cnt;
    set_in(32'd5, 32'd6, MUL);
    m_valid = 1'b1;
    a_en    = 1'b0;
    repeat (4) tick();
    m_valid = 1'b0;
    a_en    = 1'b1;
    tick();
    chk("a_en_low_no_valid", valid_cnt - v0, 32'd0);

`ifdef MUL_HI_EN
    // M_valid held through the stall: next accept happens only at T+18.
    v0 = valid_cnt;
    set_in(32'hFFFF_FFFF, 32'hFFFF_FFFF, MULXUU);
    m_valid = 1'b1;
    k = cyc;
    e.exp = 32'hFFFF_FFFE; e.at = k + 18; sbq.push_back(e);
    tick();
    set_in(32'd7, 32'd9, MUL);
    e.exp = 32'h0000_003F; e.at = k + 19; sbq.push_back(e);
    repeat (18) tick();
    m_valid = 1'b0;
    tick();
    chk("held_valid_count", valid_cnt - v0, 32'd2);

    // Reset during the 5th ITER cycle discards the op.
    set_in(32'h1234_5678, 32'h9ABC_DEF0, MULXUU);
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
`else
    drive(32'h1234_5678, 32'h0000_0003, MUL, 32'h369D_0368);
    reset_n = 1'b0;
`endif
    #1;
    chk("midreset_stall", 32'(A_mul_stall), 32'h0);
    chk("midreset_valid", 32'(A_mul_valid), 32'h0);
    chk("midreset_result", A_mul_result, 32'h0);
    sbq.delete();
    tick();
    reset_n = 1'b1;
    tick();
    drive(32'd7, 32'd9, MUL, 32'h0000_003F);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      ro = mul_op_e'($urandom_range(0, 3));
      drive(ra, rb, ro, model(ra, rb, ro));
    end

    drain();
    repeat (3) tick();
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
